// File: rtl/login_checker_multi_if.sv
// login_checker_multi_if: UART byte input and login result bundle for login_checker_multi
interface login_checker_multi_if #(
  parameter int NUM_USERS = 2,
  parameter int MAX_FAILS = 3
);
  localparam int UW = NUM_USERS > 1 ? $clog2(NUM_USERS) : 1;
  localparam int FW = $clog2(MAX_FAILS + 1);
  logic [7:0]    rx_data;
  logic          rx_data_valid;
  logic          login_success;
  logic          login_fail;
  logic [UW-1:0] user_id;
  logic          locked;
  logic [FW-1:0] fail_count;
  modport master (
    output rx_data, rx_data_valid,
    input  login_success, login_fail, user_id, locked, fail_count
  );
  modport slave (
    input  rx_data, rx_data_valid,
    output login_success, login_fail, user_id, locked, fail_count
  );
endinterface

// File: rtl/login_checker_multi.sv
// login_checker_multi: multi-user credential checker with lockout; LOGIN_TIMEOUT_EN adds an inter-byte idle timeout
module login_checker_multi #(
  parameter int NUM_USERS      = 2,
  parameter int USER_LEN       = 4,
  parameter int PASS_LEN       = 4,
  parameter logic [NUM_USERS*USER_LEN*8-1:0] USER_TABLE = "useradmn",
  parameter logic [NUM_USERS*PASS_LEN*8-1:0] PASS_TABLE = "passroot",
  parameter int MAX_FAILS      = 3,
  parameter int LOCK_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic clk,
  input logic rst_n,
  login_checker_multi_if.slave bus
);
  localparam int UW = NUM_USERS > 1 ? $clog2(NUM_USERS) : 1;
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int ML = USER_LEN > PASS_LEN ? USER_LEN : PASS_LEN;
  localparam int IW = ML > 1 ? $clog2(ML) : 1;
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, USER, PASS, DECIDE, LOCKED} state_t;

  state_t         r_state;
  logic [IW-1:0]  r_idx;
  logic [NUM_USERS-1:0] r_mv;
  logic           r_success;
  logic           r_fail;
  logic [UW-1:0]  r_user_id;
  logic           r_locked;
  logic [FW-1:0]  r_fc;
  logic [LW-1:0]  r_lock;
  logic [NUM_USERS-1:0] w_uhit;
  logic [NUM_USERS-1:0] w_phit;
  logic [UW-1:0]  w_low;
  logic [FW-1:0]  w_fc_inc;
  logic           w_abort;
  logic           w_forced;
  int             w_ui;
  int             w_pi;

  assign w_ui     = int'(r_idx) < USER_LEN ? int'(r_idx) : 0;
  assign w_pi     = int'(r_idx) < PASS_LEN ? int'(r_idx) : 0;
  assign w_fc_inc = r_fc + FW'(1);

  // per-user byte compare at the current index, and lowest surviving user
  always_comb begin
    w_uhit = '0;
    w_phit = '0;
    w_low  = '0;
    for (int u = 0; u < NUM_USERS; u++) begin
      w_uhit[u] = USER_TABLE[((NUM_USERS - u) * USER_LEN - w_ui) * 8 - 1 -: 8] == bus.rx_data;
      w_phit[u] = PASS_TABLE[((NUM_USERS - u) * PASS_LEN - w_pi) * 8 - 1 -: 8] == bus.rx_data;
    end
    for (int u = NUM_USERS - 1; u >= 0; u--)
      if (r_mv[u]) w_low = UW'(u);
  end

`ifdef LOGIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_idle;
  logic          r_force;
  assign w_abort  = (r_state == USER || r_state == PASS) && !bus.rx_data_valid &&
                    r_idle == TW'(TIMEOUT_CYCLES - 1);
  assign w_forced = r_force;
  // idle gap counter inside an attempt; a timeout forces the decision to fail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle  <= '0;
      r_force <= 1'b0;
    end else begin
      r_idle  <= (r_state == USER || r_state == PASS) && !bus.rx_data_valid && !w_abort ? r_idle + TW'(1) : '0;
      r_force <= w_abort ? 1'b1 : (r_state == DECIDE ? 1'b0 : r_force);
    end
  end
`else
  assign w_abort  = 1'b0;
  assign w_forced = 1'b0;
`endif

  // main login FSM; every byte of an attempt is consumed before deciding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_mv      <= '1;
      r_success <= 1'b0;
      r_fail    <= 1'b0;
      r_user_id <= '0;
      r_locked  <= 1'b0;
      r_fc      <= '0;
      r_lock    <= '0;
    end else begin
      r_success <= 1'b0;
      r_fail    <= 1'b0;
      case (r_state)
        IDLE: if (bus.rx_data_valid) begin
          r_mv    <= w_uhit;
          r_idx   <= USER_LEN == 1 ? IW'(0) : IW'(1);
          r_state <= USER_LEN == 1 ? PASS : USER;
        end
        USER: if (w_abort) r_state <= DECIDE;
        else if (bus.rx_data_valid) begin
          r_mv    <= r_mv & w_uhit;
          r_idx   <= r_idx == IW'(USER_LEN - 1) ? IW'(0) : r_idx + IW'(1);
          r_state <= r_idx == IW'(USER_LEN - 1) ? PASS : USER;
        end
        PASS: if (w_abort) r_state <= DECIDE;
        else if (bus.rx_data_valid) begin
          r_mv    <= r_mv & w_phit;
          r_idx   <= r_idx == IW'(PASS_LEN - 1) ? IW'(0) : r_idx + IW'(1);
          r_state <= r_idx == IW'(PASS_LEN - 1) ? DECIDE : PASS;
        end
        DECIDE: begin
          r_mv  <= '1;
          r_idx <= '0;
          if (|r_mv && !w_forced) begin
            r_success <= 1'b1;
            r_user_id <= w_low;
            r_fc      <= '0;
            r_state   <= IDLE;
          end else begin
            r_fail   <= 1'b1;
            r_fc     <= w_fc_inc;
            r_locked <= w_fc_inc == FW'(MAX_FAILS);
            r_state  <= w_fc_inc == FW'(MAX_FAILS) ? LOCKED : IDLE;
          end
        end
        LOCKED: if (r_lock == LW'(LOCK_CYCLES - 1)) begin
          r_lock   <= '0;
          r_fc     <= '0;
          r_locked <= 1'b0;
          r_state  <= IDLE;
        end else r_lock <= r_lock + LW'(1);
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.login_success = r_success;
  assign bus.login_fail    = r_fail;
  assign bus.user_id       = r_user_id;
  assign bus.locked        = r_locked;
  assign bus.fail_count    = r_fc;
endmodule

// File: doc/login_checker_multi.md
Name: login_checker_multi

Overview:
Parametrised successor to the single-user login FSM. Consumes the received UART byte stream and checks it against a compile-time table of NUM_USERS username/password pairs of configurable length. Produces one-cycle success/fail pulses and the matched user index. Adds a failed-attempt counter with timed lockout. Sits between the UART RX byte interface and the access-control logic.

Parameters:
NUM_USERS, 2, number of credential pairs (1..8)
USER_LEN, 4, username length in bytes (1..16)
PASS_LEN, 4, password length in bytes (1..16)
USER_TABLE, "useradmn", NUM_USERS*USER_LEN bytes; user 0 in the most-significant bytes, first character first
PASS_TABLE, "passroot", NUM_USERS*PASS_LEN bytes; same packing as USER_TABLE
MAX_FAILS, 3, consecutive failures that trigger lockout (>=1)
LOCK_CYCLES, 1000, lockout duration in clk cycles
TIMEOUT_CYCLES, 50000, maximum idle gap between bytes of one attempt (only used with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
rx_data  in  8  received byte
rx_data_valid  in  1  one-cycle strobe; rx_data is valid in the same cycle
login_success  out  1  one-cycle pulse: credentials matched
login_fail  out  1  one-cycle pulse: attempt rejected
user_id  out  $clog2(NUM_USERS) (min 1)  index of the matched user; valid with login_success, holds its value afterwards
locked  out  1  high during lockout
fail_count  out  $clog2(MAX_FAILS+1)  current consecutive failure count

Behaviour:
- Reset (rst_n low, asynchronous) drives the following values:
  - state=IDLE, byte index=0, match vector all ones
  - login_success=0, login_fail=0, user_id=0, locked=0, fail_count=0
  - lock counter=0
- A reset mid-attempt discards the attempt.
- The FSM has five states: IDLE, USER, PASS, DECIDE, LOCKED.
- IDLE:
  - A valid byte is treated as username byte 0: compare it, set index=1, go to USER.
  - If USER_LEN==1, go directly to PASS.
- USER:
  - Each valid byte i is compared against USER_TABLE byte i of every user.
  - A mismatch clears that user's bit in match_vec[NUM_USERS-1:0].
  - After byte USER_LEN-1, clear the index and go to PASS.
- PASS:
  - Each valid byte j is compared against PASS_TABLE byte j of every user.
  - A mismatch clears that user's bit.
  - After byte PASS_LEN-1, go to DECIDE.
- DECIDE (exactly one cycle):
  - The decision uses the match vector after the final byte has been applied. The last byte always counts.
  - If any bit is set: login_success=1, user_id=index of the lowest set bit, fail_count=0, then go to IDLE.
  - Otherwise: login_fail=1 and fail_count+1. If the new count equals MAX_FAILS, go to LOCKED; else go to IDLE.
  - Latency: the pulse is asserted on the 2nd rising edge after the last byte's valid cycle.
- A mismatch never aborts early. The full USER_LEN+PASS_LEN bytes are always consumed, so no information is leaked.
- LOCKED:
  - locked=1; all rx_data_valid strobes are ignored.
  - The counter runs LOCK_CYCLES cycles, then sets fail_count=0, locked=0 and returns to IDLE.
- Bytes arriving in DECIDE are dropped.
- Pulses are deasserted in every cycle other than DECIDE.
- Index widths are sized for max(USER_LEN,PASS_LEN); there is no wrap-around beyond the length.

Optional Feature:
Macro LOGIN_TIMEOUT_EN.
- Defined:
  - In USER or PASS, an idle counter increments every cycle without rx_data_valid and clears on each valid byte.
  - When it reaches TIMEOUT_CYCLES, the attempt is aborted and goes to DECIDE with a forced fail. This gives login_fail and increments fail_count, which may trigger lockout.
- Undefined:
  - No counter is built; an attempt waits indefinitely for bytes.

Test Plan:
- Defaults; send "user","pass" -> login_success pulse 2 edges after last byte, user_id=0, fail_count=0.
- Send "admn","root" -> login_success, user_id=1.
- Send "user","root" (cross-pair) -> login_fail, fail_count=1; all 8 bytes consumed before the pulse.
- Three wrong attempts "xxxx","yyyy" -> fail_count 1,2,3; locked=1 after the 3rd.
  - A correct login sent during lock is ignored.
  - After 1000 cycles: locked=0, fail_count=0, and a correct login then succeeds.
- Two fails then a success -> fail_count returns to 0.
- Assert rst_n low after 5 bytes, release, send "user","pass" -> success.
- With LOGIN_TIMEOUT_EN and TIMEOUT_CYCLES=20, send "us" then wait 20 idle cycles -> login_fail, fail_count=1, back in IDLE.
